// File: rtl/sub_sched_pkg.sv
// Shared definitions for the round-robin subtractor scheduler: FSM state
// type, datapath width and the round-robin pointer advance helper.
package sub_sched_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } sub_state_t;

  // Next round-robin position after ptr, wrapping at n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sub_32bit_unsigned.sv
// Shared 32-bit unsigned subtractor; borrow is bit 32 of the 33-bit difference.
module sub_32bit_unsigned (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/sub_rr_pick.sv
// Round-robin winner selection: first requester with valid set, searching
// upward from rr_ptr and wrapping at NUM_REQ. Pure combinational.
module sub_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win,
  output logic               any_valid
);

  int idx;

  // NOTE: every output of a combinational block gets a default on entry,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Scan from farthest to nearest so the candidate closest to rr_ptr wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == i && req_valid[i]) begin
          win       = ID_W'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sub_rr_scheduler.sv
// Round-robin scheduler sharing one subtractor among NUM_REQ requesters.
// Optional SUB_RR_SAT_EN: results that borrow are saturated to zero.
module sub_rr_scheduler
  import sub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_borrow
);

  sub_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic              any_valid;
  logic              accept;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [DATA_W-1:0] diff;
  logic              borrow;
  logic [DATA_W-1:0] result_next;

  sub_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .win       (win),
    .any_valid (any_valid)
  );

  assign accept = (state == IDLE) && any_valid;

  // Ready is gated by rst_n so no grant is offered while reset is held.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
    if (accept && rst_n) req_ready[win] = 1'b1;
  end

  sub_32bit_unsigned u_sub (
    .a      (op_a),
    .b      (op_b),
    .diff   (diff),
    .borrow (borrow)
  );

`ifdef SUB_RR_SAT_EN
  assign result_next = borrow ? '0 : diff;
`else
  assign result_next = diff;
`endif

  // NOTE: operand registers are pure datapath, only read in BUSY after a
  // capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a  <= sel_a;
      op_b  <= sel_b;
      op_id <= win;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            rr_ptr <= ID_W'(rr_next(int'(win), NUM_REQ));
            state  <= BUSY;
          end
        end
        BUSY: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= op_id;
          rsp_result <= result_next;
          rsp_borrow <= borrow;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
